// File: rtl/cr_prefix_int_agg.sv
// cr_prefix_int_agg: sticky event status, saturating counters, first-error capture
// and per-line interrupt FSMs. Define CR_PREFIX_INT_AGG_COALESCE_EN for holdoff coalescing.
module cr_prefix_int_agg #(
  parameter int N_SRC  = 6,
  parameter int N_OUT  = 3,
  parameter int CTR_W  = 16,
  parameter int HOLD_W = 8,
  localparam int GW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    src_evt,
  input  logic [N_SRC-1:0]    cfg_mask,
  input  logic [N_SRC*GW-1:0] cfg_grp,
  input  logic [HOLD_W-1:0]   cfg_holdoff,
  input  logic                clr_req,
  input  logic [N_SRC-1:0]    clr_vec,
  output logic [N_SRC-1:0]    status,
  output logic                first_vld,
  output logic [SW-1:0]       first_src,
  output logic [N_OUT-1:0]    int_out,
  input  logic                rd_req,
  input  logic [SW-1:0]       rd_sel,
  input  logic                rd_clr,
  output logic                rd_vld,
  output logic [CTR_W-1:0]    rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_ASSERT = 2'd2
  } st_t;

  logic [N_SRC-1:0] r_status;
  logic [CTR_W-1:0] r_cnt [N_SRC];
  logic             r_first_vld;
  logic [SW-1:0]    r_first_src;
  logic             r_rd_vld;
  logic [CTR_W-1:0] r_rd_data;
  logic [N_OUT-1:0] r_int;
  st_t              r_st [N_OUT];

  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_unm;
  logic [SW-1:0]    w_low;
  logic             w_fclr_hit;
  logic             w_first_clr;
  logic [CTR_W-1:0] w_rd_val;
  logic [N_OUT-1:0] w_pend;

  assign w_clr = clr_req ? clr_vec : '0;
  assign w_unm = src_evt & ~cfg_mask;

  // Set wins over a simultaneous W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_clr) | src_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (rd_req && rd_clr && rd_sel == SW'(i)) begin
          r_cnt[i] <= src_evt[i] ? CTR_W'(1) : '0;
        end else if (src_evt[i] && !(&r_cnt[i])) begin
          r_cnt[i] <= r_cnt[i] + CTR_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (rd_sel == SW'(i)) begin
        w_rd_val = r_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_vld  <= rd_req;
      r_rd_data <= rd_req ? w_rd_val : '0;
    end
  end

  always_comb begin
    w_low = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_unm[i]) begin
        w_low = SW'(i);
      end
    end
  end

  always_comb begin
    w_fclr_hit = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_first_src == SW'(i) && clr_vec[i]) begin
        w_fclr_hit = 1'b1;
      end
    end
  end

  assign w_first_clr = clr_req & r_first_vld & w_fclr_hit;

  // A fresh unmasked event in the clearing cycle recaptures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first_vld <= 1'b0;
      r_first_src <= '0;
    end else if ((!r_first_vld || w_first_clr) && |w_unm) begin
      r_first_vld <= 1'b1;
      r_first_src <= w_low;
    end else if (w_first_clr) begin
      r_first_vld <= 1'b0;
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < N_SRC; i++) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (r_status[i] && !cfg_mask[i] &&
            cfg_grp[i*GW +: GW] == GW'(k)) begin
          w_pend[k] = 1'b1;
        end
      end
    end
  end

`ifdef CR_PREFIX_INT_AGG_COALESCE_EN
  logic [HOLD_W-1:0] r_hold [N_OUT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        r_st[k]   <= ST_IDLE;
        r_hold[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        unique case (r_st[k])
          ST_IDLE: begin
            if (w_pend[k]) begin
              if (cfg_holdoff == '0) begin
                r_st[k]  <= ST_ASSERT;
                r_int[k] <= 1'b1;
              end else begin
                r_st[k]   <= ST_HOLD;
                r_hold[k] <= cfg_holdoff;
              end
            end
          end
          ST_HOLD: begin
            if (!w_pend[k]) begin
              r_st[k] <= ST_IDLE;
            end else if (r_hold[k] <= HOLD_W'(1)) begin
              r_st[k]   <= ST_ASSERT;
              r_hold[k] <= '0;
              r_int[k]  <= 1'b1;
            end else begin
              r_hold[k] <= r_hold[k] - HOLD_W'(1);
            end
          end
          ST_ASSERT: begin
            if (!w_pend[k]) begin
              r_st[k]  <= ST_IDLE;
              r_int[k] <= 1'b0;
            end
          end
          default: begin
            r_st[k]  <= ST_IDLE;
            r_int[k] <= 1'b0;
          end
        endcase
      end
    end
  end
`else
  logic w_unused_holdoff;
  assign w_unused_holdoff = ^cfg_holdoff;

  // HOLD is bypassed; int_out is the registered pend level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        r_st[k] <= ST_IDLE;
      end
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        unique case (r_st[k])
          ST_IDLE: begin
            if (w_pend[k]) begin
              r_st[k]  <= ST_ASSERT;
              r_int[k] <= 1'b1;
            end
          end
          ST_ASSERT: begin
            if (!w_pend[k]) begin
              r_st[k]  <= ST_IDLE;
              r_int[k] <= 1'b0;
            end
          end
          default: begin
            r_st[k]  <= w_pend[k] ? ST_ASSERT : ST_IDLE;
            r_int[k] <= w_pend[k];
          end
        endcase
      end
    end
  end
`endif

  assign status    = r_status;
  assign first_vld = r_first_vld;
  assign first_src = r_first_src;
  assign int_out   = r_int;
  assign rd_vld    = r_rd_vld;
  assign rd_data   = r_rd_data;

endmodule
